// File: rtl/button_conditioner_pkg.sv
// Purpose : shared types and helpers for the button conditioner
// Latency : n/a (package only)
// Flow    : n/a (package only)
// Contents: per-channel FSM state enum, timer width, debounce counter width helper.
// Optional: BUTTON_CONDITIONER_REPEAT_EN adds the REPEAT state.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    , REPEAT = 2'd3
`endif
  } btn_state_e;

  // Auto-repeat timer is sized for the largest allowed delay/period (65535).
  localparam int TMR_W = 16;

  // Smallest counter able to hold 0..deb without wrapping.
  function automatic int cnt_width(input int unsigned deb);
    return $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Purpose : bundle of raw button level, press pulse and debounced level
// Latency : n/a (wiring only)
// Flow    : none; level/pulse signals, no handshake
// Ports   : bi (raw level, towards conditioner), bo (press pulse), held (debounced level)
interface button_conditioner_if #(
  parameter int W = 1
);
  logic [W-1:0] bi;
  logic [W-1:0] bo;
  logic [W-1:0] held;

  // master: the side that owns the buttons and consumes the conditioned result
  modport master (output bi, input bo, input held);
  // slave: the conditioner itself
  modport slave  (input bi, output bo, output held);
endinterface

// File: rtl/button_conditioner_channel.sv
// Purpose : one button: 2-flop sync, debounce, press FSM with registered pulse
// Latency : clean input change to held/bo is DEBOUNCE+2 clock edges
// Flow    : no backpressure; bo is a one-cycle pulse, held a level
// Ports   : clk_i, rst_i (sync, active-high), ch (slave modport, 1-bit bi/bo/held)
// Optional: BUTTON_CONDITIONER_REPEAT_EN enables auto-repeat pulses while held.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  button_conditioner_if.slave  ch
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          lvl;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_q, held_d;
  btn_state_e    state_q, state_d;
  logic          bo_q, bo_d;

  // Synchroniser: nothing downstream looks at the raw input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ch.bi[0];
      sync2_q <= sync1_q;
    end
  end

  // Polarity is applied after synchronisation so the sync flops see the pin as-is.
  assign lvl = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Debounce: count consecutive cycles the level disagrees with held_q.
  // The toggle happens on the edge the count would reach DEBOUNCE, so the
  // counter itself tops out at DEBOUNCE-1 and never wraps.
  always_comb begin
    cnt_d  = '0;
    held_d = held_q;
    if (lvl != held_q) begin
      if (cnt_q == CNT_LAST) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int TW = TMR_W + 1;

  // tmr_q counts cycles since the last pulse; period_q selects the first
  // (delay) gap versus the steady repeat gap.
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             period_q, period_d;
  logic [TW-1:0]    tmr_next;
  logic [TW-1:0]    tmr_goal;
`endif

  // FSM follows held_d so that the pulse lands in the first cycle held_q is 1.
  always_comb begin
    state_d  = state_q;
    bo_d     = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    tmr_d    = '0;
    period_d = 1'b0;
    tmr_next = {1'b0, tmr_q} + TW'(1);
    tmr_goal = period_q ? TW'(REPEAT_PERIOD) : TW'(REPEAT_DELAY);
`endif
    if (!held_d) begin
      // Release (or never pressed): any due repeat pulse is dropped here.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = PRESS;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        default: begin
          if (tmr_next == tmr_goal) begin
            state_d  = REPEAT;
            period_d = 1'b1;
          end else begin
            state_d  = HOLD;
            tmr_d    = tmr_next[TMR_W-1:0];
            period_d = period_q;
          end
        end
`else
        default: state_d = HOLD;
`endif
      endcase
    end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    bo_d = (state_d == PRESS) || (state_d == REPEAT);
`else
    bo_d = (state_d == PRESS);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      held_q   <= 1'b0;
      state_q  <= IDLE;
      bo_q     <= 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      tmr_q    <= '0;
      period_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      state_q  <= state_d;
      bo_q     <= bo_d;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      tmr_q    <= tmr_d;
      period_q <= period_d;
`endif
    end
  end

  assign ch.bo   = bo_q;
  assign ch.held = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Purpose : CHANNELS independent button conditioners (sync, debounce, press pulse)
// Latency : clean Bi change to Held/Bo is DEBOUNCE+2 Clk edges
// Flow    : no backpressure; Bo one-cycle pulses, Held levels
// Ports   : Clk, Reset (sync, active-high), Bi raw levels, Bo press pulses, Held debounced levels
// Optional: define BUTTON_CONDITIONER_REPEAT_EN for auto-repeat on Bo while held.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Bi,
  output logic [CHANNELS-1:0] Bo,
  output logic [CHANNELS-1:0] Held
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_conditioner_if #(.W(1)) ch_if ();

    assign ch_if.bi = Bi[g];
    assign Bo[g]    = ch_if.bo[0];
    assign Held[g]  = ch_if.held[0];

    button_channel #(
      .DEBOUNCE      (DEBOUNCE),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk_i (Clk),
      .rst_i (Reset),
      .ch    (ch_if)
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (active-high and active-low),
// a window-based reference model checked every cycle, plus literal spot checks.
module tb_button_conditioner;

  localparam int D    = 4;
  localparam int RD   = 8;
  localparam int RP   = 4;
  localparam int MAXE = 256;

  logic       Clk;
  logic       Reset;
  logic [3:0] bi_al, bo_al, held_al;

  button_conditioner_if #(.W(4)) bus ();

  button_conditioner #(
    .CHANNELS(4), .DEBOUNCE(D), .ACTIVE_LOW(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Bi(bus.bi), .Bo(bus.bo), .Held(bus.held)
  );

  button_conditioner #(
    .CHANNELS(4), .DEBOUNCE(D), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_al (
    .Clk(Clk), .Reset(Reset), .Bi(bi_al), .Bo(bo_al), .Held(held_al)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int ecount   = 0;
  int checks   = 0;
  int failures = 0;
  int bo_cnt[4];

  // Model state per instance/channel: the synchronised level history, the
  // edge of the last held toggle or reset, and the edge of the last press.
  bit m_s1[2][4], m_s2[2][4], m_held[2][4], m_bo[2][4];
  int m_last[2][4], m_rise[2][4];
  bit m_sh[2][4][MAXE];

  task automatic model_step(input int i, input int c, input bit rst, input bit raw, input bit al);
    bit ok;
    bit rose;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    int dt;
`endif
    rose = 1'b0;
    if (rst) begin
      m_s1[i][c] = 1'b0;
      m_s2[i][c] = 1'b0;
      m_held[i][c] = 1'b0;
      m_bo[i][c] = 1'b0;
      m_last[i][c] = ecount;
      m_rise[i][c] = -1;
      m_sh[i][c][ecount] = al;
    end else begin
      // Held flips when the last D synchronised samples, all taken since the
      // previous flip/reset, disagree with it.
      ok = (ecount - D) >= m_last[i][c];
      if (ok) begin
        for (int k = ecount - D; k < ecount; k++) begin
          if (m_sh[i][c][k] == m_held[i][c]) ok = 1'b0;
        end
      end
      if (ok) begin
        m_held[i][c] = ~m_held[i][c];
        m_last[i][c] = ecount;
        rose = m_held[i][c];
      end
      m_s2[i][c] = m_s1[i][c];
      m_s1[i][c] = raw;
      m_sh[i][c][ecount] = m_s2[i][c] ^ al;
      if (rose) begin
        m_bo[i][c] = 1'b1;
        m_rise[i][c] = ecount;
      end else if (m_held[i][c]) begin
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        dt = ecount - m_rise[i][c];
        m_bo[i][c] = (dt == RD) || ((dt > RD) && (((dt - RD) % RP) == 0));
`else
        m_bo[i][c] = 1'b0;
`endif
      end else begin
        m_bo[i][c] = 1'b0;
        m_rise[i][c] = -1;
      end
    end
  endtask

  // Compare process: at each falling edge the inputs still hold the values
  // sampled by the preceding rising edge.
  initial begin
    logic [3:0] exp_bo, exp_held, got_bo, got_held;
    forever begin
      @(negedge Clk);
      ecount++;
      for (int c = 0; c < 4; c++) begin
        model_step(0, c, Reset, bus.bi[c], 1'b0);
        model_step(1, c, Reset, bi_al[c], 1'b1);
        if (bus.bo[c]) bo_cnt[c]++;
      end
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 4; c++) begin
          exp_bo[c]   = m_bo[i][c];
          exp_held[c] = m_held[i][c];
        end
        got_bo   = (i == 0) ? bus.bo   : bo_al;
        got_held = (i == 0) ? bus.held : held_al;
        checks++;
        if (got_bo !== exp_bo) begin
          failures++;
          $display("FAIL model_bo inst=%0d edge=%0d got=%b want=%b", i, ecount, got_bo, exp_bo);
        end
        checks++;
        if (got_held !== exp_held) begin
          failures++;
          $display("FAIL model_held inst=%0d edge=%0d got=%b want=%b", i, ecount, got_held, exp_held);
        end
      end
    end
  end

  task automatic wait_edge(input int n);
    while (ecount < n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic lit(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, ecount, got, want);
    end
  endtask

  task automatic lit_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", name, ecount, got, want);
    end
  endtask

  initial begin
    int c0;
    for (int c = 0; c < 4; c++) bo_cnt[c] = 0;
    Reset  = 1'b1;
    bus.bi = 4'b0000;
    bi_al  = 4'b1111;

    wait_edge(3);
    lit("rst_bo", bus.bo, 4'b0000);
    lit("rst_held", bus.held, 4'b0000);
    lit("rst_bo_al", bo_al, 4'b0000);
    lit("rst_held_al", held_al, 4'b0000);
    Reset = 1'b0;

    // Clean press on channel 0, stable before edge 10.
    wait_edge(9);  bus.bi[0] = 1'b1;
    wait_edge(14); lit("press0_pre", bus.bo | bus.held, 4'b0000);
    wait_edge(15); lit("press0_bo", bus.bo, 4'b0001);
                   lit("press0_held", bus.held, 4'b0001);
    wait_edge(16); lit("press0_one_cycle", bus.bo, 4'b0000);

    // Three-cycle glitch on channel 1.
    wait_edge(19); bus.bi[1] = 1'b1;
    wait_edge(22); bus.bi[1] = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    wait_edge(23); lit("repeat_first", bus.bo, 4'b0001);
    wait_edge(27); lit("repeat_second", bus.bo, 4'b0001);
`else
    wait_edge(23); lit("hold_quiet_a", bus.bo, 4'b0000);
    wait_edge(27); lit("hold_quiet_b", bus.bo, 4'b0000);
`endif

    // Bounce on channel 2, final rise before edge 34.
    wait_edge(29); bus.bi[2] = 1'b1;
    wait_edge(30); bus.bi[2] = 1'b0;
    wait_edge(31); bus.bi[2] = 1'b1;
    wait_edge(32); bus.bi[2] = 1'b0;
    wait_edge(33); bus.bi[2] = 1'b1;
    wait_edge(38); lit("bounce_held_pre", bus.held, 4'b0001);
    wait_edge(39); lit("bounce_bo2", {3'b000, bus.bo[2]}, 4'b0001);
                   lit("bounce_held", bus.held, 4'b0101);
                   bus.bi[3] = 1'b1;
    wait_edge(44); lit("ch3_held_pre", {3'b000, bus.held[3]}, 4'b0000);
    wait_edge(45); lit("ch3_held", {3'b000, bus.held[3]}, 4'b0001);

    // One-cycle reset while channels 0, 2, 3 are held.
    wait_edge(49);
    lit_int("glitch_pulses", bo_cnt[1], 0);
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    lit_int("bounce_pulses", bo_cnt[2], 2);
`else
    lit_int("bounce_pulses", bo_cnt[2], 1);
`endif
    Reset = 1'b1;
    wait_edge(50); Reset = 1'b0;
                   lit("midrst_held", bus.held, 4'b0000);
                   lit("midrst_bo", bus.bo, 4'b0000);
    wait_edge(55); lit("rerelease_pre", bus.bo, 4'b0000);
    wait_edge(56); lit("repress_bo", bus.bo, 4'b1101);
                   lit("repress_held", bus.held, 4'b1101);

    // Active-low instance: only channel 1 goes active.
    wait_edge(59); bi_al[1] = 1'b0;
    wait_edge(64); lit("al_pre", bo_al | held_al, 4'b0000);
    wait_edge(65); lit("al_bo", bo_al, 4'b0010);
                   lit("al_held", held_al, 4'b0010);

    // Release channel 0; held falls on the edge a repeat would be due.
    wait_edge(70); bus.bi[0] = 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    wait_edge(72); lit("repeat_late", {3'b000, bus.bo[0]}, 4'b0001);
`endif
    wait_edge(75); lit("release_pre", {3'b000, bus.held[0]}, 4'b0001);
    wait_edge(76); lit("release_held", {3'b000, bus.held[0]}, 4'b0000);
                   lit("release_bo", {3'b000, bus.bo[0]}, 4'b0000);
                   c0 = bo_cnt[0];
    wait_edge(90);
    lit_int("after_release_pulses", bo_cnt[0] - c0, 0);
    lit_int("glitch_pulses_total", bo_cnt[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
